// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder stage walks the operands LSB-first, one bit per clock,
// and gathers the sum bits and final carry into a WIDTH-bit result.

module fulladder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);
  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

// Handshakes: a transfer happens on a rising edge where valid and ready are both high;
// valid/ready are decoded from the state register only, so nothing combinational links in to out.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_sum, fa_c_out;

  fulladder u_fa (
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .c_in  (carry_q),
    .sum   (fa_sum),
    .c_out (fa_c_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_sh_d  = op_a;
          b_sh_d  = op_b;
          carry_d = c_in;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = {fa_sum, sum_sh_q[WIDTH-1:1]};
        carry_d  = fa_c_out;
        // Counter parks on LAST for the final bit so it never wraps.
        if (cnt_q == LAST) state_d = S_DONE;
        else               cnt_d   = cnt_q + 1'b1;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The result registers double as outputs; they hold through DONE and the following IDLE.
  assign sum         = sum_sh_q;
  assign c_out       = carry_q;
  assign in_ready    = (state_q == S_IDLE);
  assign busy        = (state_q == S_RUN);
  assign out_valid   = (state_q == S_DONE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed scenarios plus random traffic scored against
// plain integer addition held in an expected queue.

module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a, op_b;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         busy;
  logic [1:0]   dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [W:0] exp_q[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .c_in        (c_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sum         (sum),
    .c_out       (c_out),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    op_a = a; op_b = b; c_in = ci; in_valid = 1'b1;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 4 * W) begin
      step();
      lat++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (sum !== 8'h00) begin failures++; $display("FAIL reset_sum got=%h exp=00", sum); end
    checks++; if (c_out !== 1'b0) begin failures++; $display("FAIL reset_c_out got=%b exp=0", c_out); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int busy_cnt;
    out_ready = 1'b1;
    drive_op(8'h5A, 8'h3C, 1'b0);
    step();
    in_valid = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < W; i++) begin
      if (busy && !out_valid) busy_cnt++;
      step();
    end
    checks++; if (busy_cnt !== W) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=%0d", busy_cnt, W); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_out_valid_latency got=%b exp=1", out_valid); end
    checks++; if (sum !== 8'h96) begin failures++; $display("FAIL basic_sum got=%h exp=96", sum); end
    checks++; if (c_out !== 1'b0) begin failures++; $display("FAIL basic_c_out got=%b exp=0", c_out); end
    step();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL basic_back_to_idle got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_carry();
    logic [W-1:0] ta[3] = '{8'hFF, 8'hFF, 8'h00};
    logic [W-1:0] tb[3] = '{8'h01, 8'hFF, 8'h00};
    logic         tc[3] = '{1'b0, 1'b1, 1'b1};
    logic [W:0]   want;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      want = {1'b0, ta[i]} + {1'b0, tb[i]} + (W+1)'(tc[i]);
      drive_op(ta[i], tb[i], tc[i]);
      step();
      in_valid = 1'b0;
      wait_done(lat);
      checks++; if (lat !== W) begin failures++; $display("FAIL carry_latency[%0d] got=%0d exp=%0d", i, lat, W); end
      checks++; if ({c_out, sum} !== want) begin
        failures++; $display("FAIL carry_result[%0d] got=%b_%h exp=%b_%h", i, c_out, sum, want[W], want[W-1:0]);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    drive_op(8'hA5, 8'h5B, 1'b0);
    step();
    in_valid = 1'b0;
    wait_done(lat);
    checks++; if (out_valid !== 1'b1 || {c_out, sum} !== 9'h100) begin
      failures++; $display("FAIL bp_first_result got v=%b %b_%h exp v=1 1_00", out_valid, c_out, sum);
    end
    drive_op(8'h11, 8'h22, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (out_valid !== 1'b1 || sum !== 8'h00 || c_out !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d] got v=%b sum=%h c=%b rdy=%b busy=%b exp v=1 sum=00 c=1 rdy=0 busy=0",
                 i, out_valid, sum, c_out, in_ready, busy);
      end
    end
    out_ready = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL bp_release_idle got rdy=%b v=%b busy=%b exp 1/0/0", in_ready, out_valid, busy);
    end
    step();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bp_accept_after_idle got busy=%b exp=1", busy); end
    in_valid = 1'b0;
    wait_done(lat);
    checks++; if (out_valid !== 1'b1 || {c_out, sum} !== 9'h034) begin
      failures++; $display("FAIL bp_second_result got v=%b %b_%h exp v=1 0_34", out_valid, c_out, sum);
    end
    step();
  endtask

  task automatic test_abort();
    int seen;
    int lat;
    out_ready = 1'b1;
    drive_op(8'h12, 8'h34, 1'b0);
    step();
    in_valid = 1'b0;
    repeat (3) step();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_pre_busy got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== 8'h00 || c_out !== 1'b0) begin
      failures++;
      $display("FAIL abort_reset_values got rdy=%b v=%b busy=%b sum=%h c=%b exp 1/0/0/00/0",
               in_ready, out_valid, busy, sum, c_out);
    end
    step();
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < W + 4; i++) begin
      if (out_valid) seen++;
      step();
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL abort_no_out_valid got=%0d cycles exp=0", seen); end
    drive_op(8'h12, 8'h34, 1'b0);
    step();
    in_valid = 1'b0;
    wait_done(lat);
    checks++; if (out_valid !== 1'b1 || {c_out, sum} !== 9'h046) begin
      failures++; $display("FAIL abort_next_op got v=%b %b_%h exp v=1 0_46", out_valid, c_out, sum);
    end
    step();
  endtask

  task automatic test_random();
    int n_del = 0;
    int n_acc = 0;
    fork
      begin : driver
        logic [W-1:0] a, b;
        logic         ci;
        int           w;
        for (int k = 0; k < 200; k++) begin
          repeat ($urandom_range(0, 3)) step();
          a  = W'($urandom);
          b  = W'($urandom);
          ci = 1'($urandom_range(0, 1));
          drive_op(a, b, ci);
          w = 0;
          while (!in_ready && w < 100) begin
            step();
            w++;
          end
          if (!in_ready) begin
            failures++; checks++;
            $display("FAIL rand_accept_timeout op=%0d", k);
            in_valid = 1'b0;
            break;
          end
          exp_q.push_back({1'b0, a} + {1'b0, b} + (W+1)'(ci));
          n_acc++;
          step();
          checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rand_accept_busy op=%0d got=%b exp=1", k, busy); end
          in_valid  = 1'b0;
          op_a      = W'($urandom);
          op_b      = W'($urandom);
        end
      end
      begin : monitor
        logic [W:0] want;
        int cyc = 0;
        while (n_del < 200 && cyc < 20000) begin
          out_ready = ($urandom_range(0, 3) != 0);
          if (out_valid && in_ready) begin
            failures++; checks++;
            $display("FAIL rand_ready_in_done got in_ready=1 exp=0");
          end
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              failures++; checks++;
              $display("FAIL rand_spurious_result got=%b_%h exp=none", c_out, sum);
            end else begin
              want = exp_q.pop_front();
              checks++; if ({c_out, sum} !== want) begin
                failures++;
                $display("FAIL rand_result[%0d] got=%b_%h exp=%b_%h", n_del, c_out, sum, want[W], want[W-1:0]);
              end
            end
            n_del++;
          end
          step();
          cyc++;
        end
      end
    join
    checks++; if (n_del !== 200 || n_acc !== 200) begin
      failures++; $display("FAIL rand_count got acc=%0d del=%0d exp=200/200", n_acc, n_del);
    end
    checks++; if (exp_q.size() !== 0) begin
      failures++; $display("FAIL rand_leftover got=%0d exp=0", exp_q.size());
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    c_in      = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
